// File: rtl/bank_sched_pkg.sv
// ---------------------------------------------------------------------------
// bank_sched_pkg
//
// Shared definitions for the column-bank scheduler of the 2D convolution
// datapath.
//   N            number of convolvers; the scheduler owns N+2 column banks
//   BITS_DATA    width of one memory word
//   BITS_IMAGEN  width of one pixel fed to a convolver
//   NBANKS       bank count (N+2)
//   BANK_W       width of a bank index
//   sched_state_t  IDLE / LOAD / RUN / DONE
//   bank_add()   bank index arithmetic modulo the bank count
// ---------------------------------------------------------------------------
package bank_sched_pkg;

    localparam int N           = 2;
    localparam int BITS_DATA   = 13;
    localparam int BITS_IMAGEN = 8;
    localparam int NBANKS      = N + 2;
    localparam int BANK_W      = $clog2(NBANKS);

    typedef logic [BANK_W-1:0] bank_idx_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_DONE
    } sched_state_t;

    // Every caller adds less than the bank count to an index that is
    // already in range, so a single conditional subtraction is enough to
    // bring the sum back into 0..nbanks-1.
    function automatic bank_idx_t bank_add(input bank_idx_t idx,
                                           input int        inc,
                                           input int        nbanks);
        int sum;
        sum = int'(idx) + inc;
        if (sum >= nbanks) begin
            sum = sum - nbanks;
        end
        return bank_idx_t'(sum);
    endfunction

endpackage

// File: rtl/bank_sched_if.sv
// ---------------------------------------------------------------------------
// bank_sched_if
//
// Bundle between the control FSM / memory banks / convolvers and the
// bank scheduler.
//   i_load, i_sop, i_chblk, i_eop  FSM phase requests and pulses
//   i_wvalid, i_Data               image word written during LOAD
//   i_cvalid, i_DataConv           convolver results (conv k at slice k)
//   i_MemData                      bank read data (bank j at slice j)
//   o_we, o_MemData                per-bank write enable and write data
//   o_DataConv                     convolver pixels (conv k pixel i at 3k+i)
//   o_Data                         readback word in DONE
//   o_busy, o_done                 phase status
// master: the controller/memory side; slave: the scheduler itself.
// ---------------------------------------------------------------------------
interface bank_sched_if;
    import bank_sched_pkg::*;

    logic                             i_load;
    logic                             i_sop;
    logic                             i_chblk;
    logic                             i_eop;
    logic                             i_wvalid;
    logic [BITS_IMAGEN-1:0]           i_Data;
    logic                             i_cvalid;
    logic [N*BITS_DATA-1:0]           i_DataConv;
    logic [NBANKS*BITS_DATA-1:0]      i_MemData;
    logic [NBANKS-1:0]                o_we;
    logic [NBANKS*BITS_DATA-1:0]      o_MemData;
    logic [3*N*BITS_IMAGEN-1:0]       o_DataConv;
    logic [BITS_DATA-1:0]             o_Data;
    logic                             o_busy;
    logic                             o_done;

    modport master (
        output i_load, i_sop, i_chblk, i_eop,
        output i_wvalid, i_Data, i_cvalid, i_DataConv, i_MemData,
        input  o_we, o_MemData, o_DataConv, o_Data, o_busy, o_done
    );

    modport slave (
        input  i_load, i_sop, i_chblk, i_eop,
        input  i_wvalid, i_Data, i_cvalid, i_DataConv, i_MemData,
        output o_we, o_MemData, o_DataConv, o_Data, o_busy, o_done
    );

endinterface

// File: rtl/bank_sched_tap3.sv
// ---------------------------------------------------------------------------
// bank_tap3
//
// Pixel tap for one convolver: picks the three consecutive banks starting
// at first_bank (wrapping around the bank ring) and keeps the low
// BITS_IMAGEN bits of each word.
//   mem_data    all bank read words, bank j at slice j
//   first_bank  bank feeding pixel 0
//   pixels      pixel i at slice i
// ---------------------------------------------------------------------------
module bank_tap3
    import bank_sched_pkg::*;
(
    input  logic [NBANKS*BITS_DATA-1:0] mem_data,
    input  bank_idx_t                   first_bank,
    output logic [3*BITS_IMAGEN-1:0]    pixels
);

    // Each pixel comes from the bank i places after first_bank; the bank
    // word is wider than a pixel, so only its low bits are forwarded.
    always_comb begin : tap_select
        bank_idx_t src;
        pixels = '0;
        src    = '0;
        for (int i = 0; i < 3; i++) begin
            src = bank_add(first_bank, i, NBANKS);
            pixels[i*BITS_IMAGEN +: BITS_IMAGEN] =
                mem_data[int'(src)*BITS_DATA +: BITS_IMAGEN];
        end
    end

endmodule

// File: rtl/bank_sched.sv
// ---------------------------------------------------------------------------
// bank_sched
//
// Column-bank scheduler for the 2D convolution datapath. Owns the N+2
// column banks and decides each cycle which bank is written, which three
// banks feed every convolver and where convolver results are stored,
// using a rotating base pointer instead of ad-hoc bank selection.
//   i_CLK    clock, all state on the rising edge
//   i_reset  synchronous active-high reset; also blocks writes in the
//            cycle it is asserted
//   bus      bank_sched_if slave modport (FSM pulses, image and convolver
//            data in, bank write/readback and convolver pixels out)
//
// Phases:
//   IDLE  pointers held at 0, nothing written
//   LOAD  image words written to bank wptr; i_chblk moves to next bank
//   RUN   convolver k reads banks base+k..base+k+2 and writes its result
//         to bank base+k; i_chblk advances base by N
//   DONE  bank rptr is read back on o_Data; i_chblk moves to next bank
// Pulse priority is i_eop > i_sop > i_chblk.
// ---------------------------------------------------------------------------
module bank_sched
    import bank_sched_pkg::*;
(
    input  logic        i_CLK,
    input  logic        i_reset,
    bank_sched_if.slave bus
);

    sched_state_t state;
    sched_state_t state_nxt;
    bank_idx_t    base;
    bank_idx_t    base_nxt;
    bank_idx_t    wptr;
    bank_idx_t    wptr_nxt;
    bank_idx_t    rptr;
    bank_idx_t    rptr_nxt;
    logic         chblk_ok;

    logic [NBANKS-1:0]            we;
    logic [NBANKS*BITS_DATA-1:0]  mem_wdata;
    logic [3*N*BITS_IMAGEN-1:0]   conv_data;
    logic [BITS_DATA-1:0]         rd_data;
    logic [3*N*BITS_IMAGEN-1:0]   taps;

    // State and bank pointers are the only storage in the block.
    always_ff @(posedge i_CLK) begin
        if (i_reset) begin
            state <= ST_IDLE;
            base  <= '0;
            wptr  <= '0;
            rptr  <= '0;
        end else begin
            state <= state_nxt;
            base  <= base_nxt;
            wptr  <= wptr_nxt;
            rptr  <= rptr_nxt;
        end
    end

    // A change-block pulse only moves a pointer when no higher-priority
    // pulse arrives in the same cycle; in particular a final column done
    // together with end-of-processing leaves base where it was.
    assign chblk_ok = bus.i_chblk && !bus.i_eop && !bus.i_sop;

    // Phase sequencing and pointer updates.
    always_comb begin
        state_nxt = state;
        base_nxt  = base;
        wptr_nxt  = wptr;
        rptr_nxt  = rptr;
        case (state)
            ST_IDLE: begin
                base_nxt = '0;
                wptr_nxt = '0;
                rptr_nxt = '0;
                if (bus.i_load) begin
                    state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (bus.i_sop) begin
                    state_nxt = ST_RUN;
                    base_nxt  = '0;
                end else if (chblk_ok) begin
                    wptr_nxt = bank_add(wptr, 1, NBANKS);
                end
            end
            ST_RUN: begin
                if (bus.i_eop) begin
                    state_nxt = ST_DONE;
                end else if (chblk_ok) begin
                    base_nxt = bank_add(base, N, NBANKS);
                end
            end
            ST_DONE: begin
                if (bus.i_load) begin
                    state_nxt = ST_LOAD;
                    wptr_nxt  = '0;
                end else if (chblk_ok) begin
                    rptr_nxt = bank_add(rptr, 1, NBANKS);
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // One tap per convolver; convolver k window starts at bank base+k.
    generate
        for (genvar k = 0; k < N; k++) begin : g_tap
            bank_idx_t first_bank;
            assign first_bank = bank_add(base, k, NBANKS);
            bank_tap3 u_tap (
                .mem_data   (bus.i_MemData),
                .first_bank (first_bank),
                .pixels     (taps[3*k*BITS_IMAGEN +: 3*BITS_IMAGEN])
            );
        end
    endgenerate

    // Bank write path and readback are combinational so the memories can
    // capture the word on the same edge the scheduler decides to write it.
    // Slices not addressed in the current phase stay at zero. Reset forces
    // the write enables low immediately so an aborted run cannot corrupt a
    // bank on its way back to IDLE.
    always_comb begin : out_path
        bank_idx_t wbank;
        we        = '0;
        mem_wdata = '0;
        conv_data = '0;
        rd_data   = '0;
        wbank     = '0;
        case (state)
            ST_LOAD: begin
                mem_wdata[int'(wptr)*BITS_DATA +: BITS_DATA] =
                    BITS_DATA'(bus.i_Data);
                if (bus.i_wvalid) begin
                    we[wptr] = 1'b1;
                end
            end
            ST_RUN: begin
                conv_data = taps;
                for (int k = 0; k < N; k++) begin
                    wbank = bank_add(base, k, NBANKS);
                    mem_wdata[int'(wbank)*BITS_DATA +: BITS_DATA] =
                        bus.i_DataConv[k*BITS_DATA +: BITS_DATA];
                    if (bus.i_cvalid) begin
                        we[wbank] = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                rd_data = bus.i_MemData[int'(rptr)*BITS_DATA +: BITS_DATA];
            end
            default: begin
            end
        endcase
        if (i_reset) begin
            we = '0;
        end
    end

    assign bus.o_we       = we;
    assign bus.o_MemData  = mem_wdata;
    assign bus.o_DataConv = conv_data;
    assign bus.o_Data     = rd_data;
    assign bus.o_busy     = (state == ST_LOAD) || (state == ST_RUN);
    assign bus.o_done     = (state == ST_DONE);

endmodule

// File: tb/tb_bank_sched.sv
// ---------------------------------------------------------------------------
// tb_bank_sched
//
// Directed bench for bank_sched with N=2 (four banks). The stimulus thread
// drives one cycle at a time and queues the response it expects for that
// cycle; a monitor on the falling edge pops each expectation and compares
// the selected outputs. A small bank memory model closes the loop from
// o_we/o_MemData back to i_MemData.
// ---------------------------------------------------------------------------
module tb_bank_sched;
    import bank_sched_pkg::*;

    localparam int MW = NBANKS * BITS_DATA;
    localparam int CW = 3 * N * BITS_IMAGEN;
    localparam int DW = N * BITS_DATA;

    localparam logic [5:0] M_WE   = 6'd1;
    localparam logic [5:0] M_MEM  = 6'd2;
    localparam logic [5:0] M_CONV = 6'd4;
    localparam logic [5:0] M_DATA = 6'd8;
    localparam logic [5:0] M_BUSY = 6'd16;
    localparam logic [5:0] M_DONE = 6'd32;
    localparam logic [5:0] M_ALL  = 6'd63;

    typedef struct {
        string                 name;
        logic [5:0]            mask;
        logic [NBANKS-1:0]     we;
        logic [MW-1:0]         mem;
        logic [CW-1:0]         conv;
        logic [BITS_DATA-1:0]  data;
        logic                  busy;
        logic                  done;
    } exp_t;

    logic i_CLK = 1'b0;
    logic i_reset;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    logic [BITS_DATA-1:0] mem [NBANKS];
    logic [BITS_DATA-1:0] preload_val [NBANKS];
    logic                 preload_en;

    bank_sched_if bus();

    bank_sched dut (
        .i_CLK   (i_CLK),
        .i_reset (i_reset),
        .bus     (bus)
    );

    always #5 i_CLK = ~i_CLK;

    // Bank memories: either loaded directly by the bench or written
    // through the scheduler's write enables.
    always @(posedge i_CLK) begin
        for (int b = 0; b < NBANKS; b++) begin
            if (preload_en) begin
                mem[b] <= preload_val[b];
            end else if (bus.o_we[b]) begin
                mem[b] <= bus.o_MemData[b*BITS_DATA +: BITS_DATA];
            end
        end
    end

    assign bus.i_MemData = {mem[3], mem[2], mem[1], mem[0]};

    function automatic logic [MW-1:0] slot(input logic [BITS_DATA-1:0] val,
                                           input int idx);
        return MW'(val) << (BITS_DATA * idx);
    endfunction

    task automatic tally(input string name, input string field,
                         input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s.%s got %h want %h", name, field, got, want);
        end
    endtask

    // Monitor: one queued expectation is checked per cycle, away from the
    // active edge.
    always @(negedge i_CLK) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            if ((e.mask & M_WE)   != 0) tally(e.name, "we",   64'(bus.o_we),       64'(e.we));
            if ((e.mask & M_MEM)  != 0) tally(e.name, "mem",  64'(bus.o_MemData),  64'(e.mem));
            if ((e.mask & M_CONV) != 0) tally(e.name, "conv", 64'(bus.o_DataConv), 64'(e.conv));
            if ((e.mask & M_DATA) != 0) tally(e.name, "data", 64'(bus.o_Data),     64'(e.data));
            if ((e.mask & M_BUSY) != 0) tally(e.name, "busy", 64'(bus.o_busy),     64'(e.busy));
            if ((e.mask & M_DONE) != 0) tally(e.name, "done", 64'(bus.o_done),     64'(e.done));
        end
    end

    task automatic applyStimulus(input logic rst, input logic ld,
                                 input logic sop, input logic chb,
                                 input logic eop, input logic wv,
                                 input logic [BITS_IMAGEN-1:0] d,
                                 input logic cv, input logic [DW-1:0] dc);
        @(posedge i_CLK);
        #1;
        i_reset        = rst;
        bus.i_load     = ld;
        bus.i_sop      = sop;
        bus.i_chblk    = chb;
        bus.i_eop      = eop;
        bus.i_wvalid   = wv;
        bus.i_Data     = d;
        bus.i_cvalid   = cv;
        bus.i_DataConv = dc;
    endtask

    task automatic checkOutput(input string name, input logic [5:0] mask,
                               input logic [NBANKS-1:0] we,
                               input logic [MW-1:0] memv,
                               input logic [CW-1:0] conv,
                               input logic [BITS_DATA-1:0] data,
                               input logic busy, input logic done);
        exp_t e;
        e.name = name;
        e.mask = mask;
        e.we   = we;
        e.mem  = memv;
        e.conv = conv;
        e.data = data;
        e.busy = busy;
        e.done = done;
        sb.push_back(e);
    endtask

    initial begin
        logic [NBANKS-1:0] load_we [5];
        int                load_ptr [5];
        load_we  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        load_ptr = '{0, 1, 2, 3, 0};

        i_reset        = 1'b1;
        bus.i_load     = 1'b0;
        bus.i_sop      = 1'b0;
        bus.i_chblk    = 1'b0;
        bus.i_eop      = 1'b0;
        bus.i_wvalid   = 1'b0;
        bus.i_Data     = '0;
        bus.i_cvalid   = 1'b0;
        bus.i_DataConv = '0;
        preload_val    = '{default: '0};
        preload_en     = 1'b1;

        // Reset
        applyStimulus(1, 0, 0, 0, 0, 0, '0, 0, '0);
        applyStimulus(1, 0, 0, 0, 0, 0, '0, 0, '0);
        checkOutput("rst_hold", M_WE | M_BUSY | M_DONE, '0, '0, '0, '0, 0, 0);
        preload_en = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, '0, 0, '0);
        checkOutput("reset", M_ALL, '0, '0, '0, '0, 0, 0);

        // LOAD: five words, bank pointer wraps after bank 3
        applyStimulus(0, 1, 0, 0, 0, 0, '0, 0, '0);
        checkOutput("idle_load", M_WE | M_BUSY, '0, '0, '0, '0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 0, 0, 1, 0, 1, 8'hA5, 0, '0);
            checkOutput($sformatf("load%0d", i), M_WE | M_MEM | M_CONV | M_BUSY | M_DONE,
                        load_we[i], slot(13'h0A5, load_ptr[i]), '0, '0, 1, 0);
        end

        // Preload distinct bank words; no write strobe without i_wvalid
        preload_val = '{13'h011, 13'h022, 13'h033, 13'h044};
        applyStimulus(0, 0, 0, 0, 0, 0, 8'h77, 0, '0);
        preload_en = 1'b1;
        checkOutput("load_nowv", M_WE | M_BUSY, '0, '0, '0, '0, 1, 0);
        applyStimulus(0, 0, 1, 0, 0, 0, '0, 0, '0);
        preload_en = 1'b0;
        checkOutput("sop", M_WE | M_BUSY | M_DONE, '0, '0, '0, '0, 1, 0);

        // RUN at base 0, then advance to base 2
        applyStimulus(0, 0, 0, 1, 0, 0, '0, 0, '0);
        checkOutput("run_b0", M_WE | M_CONV | M_BUSY | M_DONE, '0, '0,
                    48'h44_33_22_33_22_11, '0, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, '0, 1, {13'h200, 13'h100});
        checkOutput("run_b2_wr", M_WE | M_MEM | M_CONV, 4'b1100,
                    slot(13'h100, 2) | slot(13'h200, 3),
                    48'h22_11_44_11_44_33, '0, 1, 0);
        applyStimulus(0, 0, 0, 1, 1, 0, '0, 0, '0);
        checkOutput("chblk_eop", M_WE | M_CONV | M_BUSY, '0, '0,
                    48'h22_11_00_11_00_00, '0, 1, 0);

        // DONE readback, rptr wraps to bank 0
        applyStimulus(0, 0, 0, 1, 0, 0, '0, 0, '0);
        checkOutput("rd0", M_WE | M_CONV | M_DATA | M_BUSY | M_DONE, '0, '0, '0, 13'h011, 0, 1);
        applyStimulus(0, 0, 0, 1, 0, 0, '0, 0, '0);
        checkOutput("rd1", M_DATA | M_DONE, '0, '0, '0, 13'h022, 0, 1);
        applyStimulus(0, 0, 0, 1, 0, 0, '0, 0, '0);
        checkOutput("rd2", M_DATA | M_DONE, '0, '0, '0, 13'h100, 0, 1);
        applyStimulus(0, 0, 0, 1, 0, 0, '0, 0, '0);
        checkOutput("rd3", M_DATA | M_DONE, '0, '0, '0, 13'h200, 0, 1);
        applyStimulus(0, 0, 1, 0, 0, 0, '0, 0, '0);
        checkOutput("rd_wrap", M_DATA | M_DONE, '0, '0, '0, 13'h011, 0, 1);
        applyStimulus(0, 1, 0, 0, 0, 0, '0, 0, '0);
        checkOutput("sop_ignored", M_WE | M_DATA | M_BUSY | M_DONE, '0, '0, '0, 13'h011, 0, 1);

        // Reload from DONE restarts at bank 0; i_load inside LOAD ignored
        applyStimulus(0, 1, 0, 0, 0, 1, 8'h5A, 0, '0);
        checkOutput("reload0", M_WE | M_MEM | M_DATA | M_BUSY | M_DONE, 4'b0001,
                    slot(13'h05A, 0), '0, '0, 1, 0);
        applyStimulus(0, 0, 1, 0, 0, 1, 8'h5A, 0, '0);
        checkOutput("reload1", M_WE | M_BUSY, 4'b0001, '0, '0, '0, 1, 0);

        // Reset mid-RUN with results valid: no write that cycle
        applyStimulus(1, 0, 0, 0, 0, 0, '0, 1, {13'h0AB, 13'h0CD});
        checkOutput("rst_run", M_WE | M_CONV | M_BUSY, '0, '0,
                    48'h00_00_22_00_22_5A, '0, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, '0, 1, {13'h0AB, 13'h0CD});
        checkOutput("after_rst", M_WE | M_CONV | M_DATA | M_BUSY | M_DONE, '0, '0, '0, '0, 0, 0);

        applyStimulus(0, 0, 0, 0, 0, 0, '0, 0, '0);
        repeat (3) @(posedge i_CLK);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain pending %0d want 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
